avalon_reg_bank: RTL and testbench

- Avalon-MM register-bank slave sitting directly downstream of the AXI-Lite-to-Avalon bridge. It consumes that bridge's byte address, byteenable, read, write and writedata, and returns readdata with a waitrequest handshake.
- Provides an ID register, control/status registers, a free-running counter with compare interrupt, and a scratch RAM.
- Read latency is fixed and programmable, so bridge timing can be exercised.

---
 rtl/avalon_reg_bank_if.sv | 23 ++
 rtl/avalon_reg_bank.sv | 168 ++++++++++++++++
 tb/tb_avalon_reg_bank.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_reg_bank_if.sv
// Avalon-MM slave-side bus bundle between the AXI-Lite bridge and the register bank.
interface avalon_reg_bank_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   avs_address;
  logic [DATA_WIDTH/8-1:0] avs_byteenable;
  logic                    avs_read;
  logic                    avs_write;
  logic [DATA_WIDTH-1:0]   avs_writedata;
  logic [DATA_WIDTH-1:0]   avs_readdata;
  logic                    avs_waitrequest;

  modport master (
    output avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_byteenable, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/avalon_reg_bank.sv
// Avalon-MM register bank: ID, CTRL/STATUS, free-running COUNT with compare irq,
// scratch RAM, with a fixed programmable access latency.
module avalon_reg_bank #(
  parameter int          ADDR_WIDTH  = 11,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_SCRATCH = 16,
  parameter int          RD_LAT      = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5A5_0001
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  avalon_reg_bank_if.slave  bus,
  output logic              irq
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int SCR_IW = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [WORD_W-1:0] W_ID    = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_CTRL  = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_STAT  = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_CNT   = WORD_W'(3);
  localparam logic [WORD_W-1:0] W_CMP   = WORD_W'(4);
  localparam logic [WORD_W-1:0] SCR_LO  = WORD_W'(64);
  localparam logic [WORD_W-1:0] SCR_END = WORD_W'(64 + NUM_SCRATCH);
  localparam logic [3:0]        WCNT_LD = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [WORD_W-1:0]       word_q;
  logic [NB-1:0]           be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    wr_q, both_q;

  logic [1:0]              ctrl_q, ctrl_d;
  logic [1:0]              status_q, status_d;
  logic [DATA_WIDTH-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]   compare_q, compare_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    irq_q;
  logic [DATA_WIDTH-1:0]   scratch_q [NUM_SCRATCH];

  logic                    req, commit, wr_commit, ld_rd, match;
  logic [WORD_W-1:0]       acc_word, scr_off;
  logic                    acc_wr;
  logic [SCR_IW-1:0]       scr_idx;
  logic                    sel_id, sel_ctrl, sel_stat, sel_cnt, sel_cmp, sel_scr, mapped;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic                    unused_bits;

  function automatic logic [DATA_WIDTH-1:0] be_merge(input logic [DATA_WIDTH-1:0] old_v,
                                                     input logic [DATA_WIDTH-1:0] new_v,
                                                     input logic [NB-1:0]         be);
    be_merge = old_v;
    for (int b = 0; b < NB; b++)
      if (be[b]) be_merge[8*b +: 8] = new_v[8*b +: 8];
  endfunction

  assign req                 = bus.avs_read | bus.avs_write;
  assign bus.avs_waitrequest = req & (state_q != S_ACK);
  assign bus.avs_readdata    = rdata_q;
  assign irq                 = irq_q;

  // In IDLE the live bus is decoded so a zero-latency read can load readdata
  // on the same edge that latches the request; otherwise the latched copy is used.
  assign acc_word = (state_q == S_IDLE) ? bus.avs_address[ADDR_WIDTH-1:2] : word_q;
  assign acc_wr   = (state_q == S_IDLE) ? bus.avs_write : wr_q;

  assign sel_id   = (acc_word == W_ID);
  assign sel_ctrl = (acc_word == W_CTRL);
  assign sel_stat = (acc_word == W_STAT);
  assign sel_cnt  = (acc_word == W_CNT);
  assign sel_cmp  = (acc_word == W_CMP);
  assign sel_scr  = (acc_word >= SCR_LO) && (acc_word < SCR_END);
  assign mapped   = sel_id | sel_ctrl | sel_stat | sel_cnt | sel_cmp | sel_scr;
  assign scr_off  = acc_word - SCR_LO;
  assign scr_idx  = scr_off[SCR_IW-1:0];
  assign unused_bits = ^{bus.avs_address[1:0], scr_off};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: if (req) begin
        // RD_LAT BUSY cycles between the IDLE cycle and ACK
        state_d = (RD_LAT == 0) ? S_ACK : S_BUSY;
        wcnt_d  = WCNT_LD;
      end
      S_BUSY: if (wcnt_q == 4'd0) state_d = S_ACK;
              else                wcnt_d  = wcnt_q - 4'd1;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign commit    = (state_q == S_ACK);
  assign wr_commit = commit & wr_q;
  assign ld_rd     = (state_d == S_ACK) && (state_q != S_ACK) && !acc_wr;
  assign match     = ctrl_q[0] && (count_q == compare_q);

  always_comb begin
    rd_val = 32'hDEAD_BEEF;
    if (sel_id)   rd_val = ID_VALUE;
    if (sel_ctrl) rd_val = {{(DATA_WIDTH-2){1'b0}}, ctrl_q};
    if (sel_stat) rd_val = {{(DATA_WIDTH-2){1'b0}}, status_q};
    if (sel_cnt)  rd_val = count_q;
    if (sel_cmp)  rd_val = compare_q;
    if (sel_scr)  rd_val = scratch_q[scr_idx];
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    status_d  = status_q;
    count_d   = count_q;
    compare_d = compare_q;
    if (wr_commit && sel_ctrl && be_q[0]) ctrl_d = wdata_q[1:0];
    if (wr_commit && sel_stat && be_q[0]) status_d = status_q & ~wdata_q[1:0];
    // hardware set beats a same-edge write-1-to-clear
    if (match) status_d[0] = 1'b1;
    if (commit && (!mapped || both_q)) status_d[1] = 1'b1;
    if (ctrl_q[0]) count_d = count_q + 1'b1;
    if (wr_commit && sel_cnt) count_d = be_merge(count_q, wdata_q, be_q);
    if (wr_commit && sel_cmp) compare_d = be_merge(compare_q, wdata_q, be_q);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      word_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      both_q    <= 1'b0;
      ctrl_q    <= '0;
      status_q  <= '0;
      count_q   <= '0;
      compare_q <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      if (state_q == S_IDLE && req) begin
        word_q  <= bus.avs_address[ADDR_WIDTH-1:2];
        be_q    <= bus.avs_byteenable;
        wdata_q <= bus.avs_writedata;
        wr_q    <= bus.avs_write;
        both_q  <= bus.avs_read & bus.avs_write;
      end
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      if (ld_rd) rdata_q <= rd_val;
      irq_q     <= status_q[0] & ctrl_q[1];
    end
  end

  // Scratch is RAM: not cleared by reset, and an aborted write never reaches it.
  always_ff @(posedge ACLK) begin
    if (ARESETN && wr_commit && sel_scr)
      scratch_q[scr_idx] <= be_merge(scratch_q[scr_idx], wdata_q, be_q);
  end

endmodule

// File: tb/tb_avalon_reg_bank.sv
// Randomized self-checking bench for avalon_reg_bank against a map-level model.
module tb_avalon_reg_bank;
  localparam int          AW  = 11;
  localparam int          NS  = 16;
  localparam int          RL  = 1;
  localparam logic [31:0] IDV = 32'hA5A5_0001;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic irq;

  avalon_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  avalon_reg_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_SCRATCH(NS),
                    .RD_LAT(RL), .ID_VALUE(IDV)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus), .irq(irq));

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // register-map model
  logic [31:0] m_scr [NS];
  logic [1:0]  m_ctrl, m_stat;
  logic [31:0] m_cnt, m_cmp, m_last_rd;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_mapped(input int w);
    return (w <= 4) || (w >= 64 && w < 64 + NS);
  endfunction

  function automatic logic [31:0] m_read(input int w);
    case (w)
      0: return IDV;
      1: return {30'b0, m_ctrl};
      2: return {30'b0, m_stat};
      3: return m_cnt;
      4: return m_cmp;
      default: return (w >= 64 && w < 64 + NS) ? m_scr[w-64] : 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic m_write(input int w, input logic [3:0] be, input logic [31:0] wd);
    case (w)
      1: if (be[0]) m_ctrl = wd[1:0];
      2: if (be[0]) m_stat = m_stat & ~wd[1:0];
      3: m_cnt = merge(m_cnt, wd, be);
      4: m_cmp = merge(m_cmp, wd, be);
      default: if (w >= 64 && w < 64 + NS) m_scr[w-64] = merge(m_scr[w-64], wd, be);
    endcase
  endtask

  task automatic m_reset();
    m_ctrl = '0; m_stat = '0; m_cnt = '0; m_cmp = '0; m_last_rd = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the ACK cycle.
  task automatic xfer(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rdata, output int cyc);
    bus.avs_address = a; bus.avs_byteenable = be; bus.avs_writedata = wd;
    bus.avs_read = rd; bus.avs_write = wr;
    cyc = 0;
    do begin @(negedge ACLK); cyc++; end while (bus.avs_waitrequest && cyc < 40);
    if (cyc >= 40) chk("ack_timeout", {31'b0, bus.avs_waitrequest}, 32'd0);
    rdata = bus.avs_readdata;
    @(posedge ACLK); #1;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input string tag);
    logic [31:0] rdata, exp;
    int cyc, w;
    w = int'(a[AW-1:2]);
    xfer(rd, wr, a, be, wd, rdata, cyc);
    chk({tag, "_lat"}, cyc, RL + 2);
    if (wr) begin
      chk({tag, "_rdhold"}, rdata, m_last_rd);
      m_write(w, be, wd);
      if (!is_mapped(w) || rd) m_stat[1] = 1'b1;
    end else begin
      exp = m_read(w);
      chk(tag, rdata, exp);
      m_last_rd = exp;
      if (!is_mapped(w)) m_stat[1] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rdata, wd, base;
    logic [AW-1:0] a;
    logic [3:0] be;
    int cyc, w, r, first;

    bus.avs_address = '0; bus.avs_byteenable = '0; bus.avs_writedata = '0;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    m_reset();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_rdata", bus.avs_readdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_wait", {31'b0, bus.avs_waitrequest}, 32'd0);
    @(posedge ACLK); #1 ARESETN = 1'b1;

    do_op(1, 0, 11'h000, 4'hF, 0, "id");

    for (int i = 0; i < NS; i++) do_op(0, 1, AW'(32'h100 + 4*i), 4'hF, 32'd0, "scr_init");

    do_op(0, 1, 11'h104, 4'b0101, 32'h1234_5678, "be_wr");
    do_op(1, 0, 11'h104, 4'hF, 0, "be_rd");
    chk("be_rd_const", m_last_rd, 32'h0034_0078);
    do_op(0, 1, 11'h104, 4'hF, 32'h1122_3344, "full_wr");
    do_op(1, 0, 11'h104, 4'hF, 0, "full_rd");

    // random traffic; counter stays disabled so every read value is static
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 2))
        0: a = AW'(($urandom_range(0, 4) << 2) | $urandom_range(0, 3));
        1: a = AW'((64 + $urandom_range(0, NS-1)) << 2);
        default: a = AW'($urandom);
      endcase
      w  = int'(a[AW-1:2]);
      be = 4'($urandom);
      wd = $urandom;
      if (w == 1) wd[0] = 1'b0;
      r = $urandom_range(0, 9);
      if (r < 5)      do_op(1, 0, a, be, wd, "rnd_rd");
      else if (r < 9) do_op(0, 1, a, be, wd, "rnd_wr");
      else            do_op(1, 1, a, be, wd, "rnd_both");
      chk("rnd_irq", {31'b0, irq}, {31'b0, m_stat[0] & m_ctrl[1]});
    end

    // compare interrupt
    do_op(0, 1, 11'h008, 4'hF, 32'h3, "st_clr");
    do_op(0, 1, 11'h004, 4'hF, 32'h0, "ctrl_off");
    do_op(0, 1, 11'h010, 4'hF, 32'd20, "cmp_wr");
    do_op(0, 1, 11'h00C, 4'hF, 32'd0, "cnt_wr");
    xfer(0, 1, 11'h004, 4'hF, 32'h3, rdata, cyc);
    m_ctrl = 2'b11;
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge ACLK);
      if (irq && first == 0) first = n;
    end
    // COUNT is k after the k-th edge past the CTRL commit; match at 20 sets STATUS, irq one later
    chk("irq_rise", first, 23);
    m_stat[0] = 1'b1;
    @(posedge ACLK); #1;
    do_op(1, 0, 11'h008, 4'hF, 0, "st_match");
    xfer(0, 1, 11'h008, 4'hF, 32'h1, rdata, cyc);
    m_stat[0] = 1'b0;
    @(negedge ACLK); chk("irq_lag", {31'b0, irq}, 32'd1);
    @(negedge ACLK); chk("irq_drop", {31'b0, irq}, 32'd0);
    @(posedge ACLK); #1;
    do_op(1, 0, 11'h008, 4'hF, 0, "st_cleared");

    // unmapped access
    do_op(1, 0, 11'h7F0, 4'hF, 0, "unmapped");
    do_op(1, 0, 11'h008, 4'hF, 0, "st_err");
    do_op(0, 1, 11'h008, 4'h1, 32'h2, "st_err_clr");
    do_op(1, 0, 11'h008, 4'hF, 0, "st_err_gone");

    // counter wrap and write-over-increment
    do_op(0, 1, 11'h004, 4'hF, 32'h2, "ctrl_stop");
    do_op(0, 1, 11'h00C, 4'hF, 32'hFFFF_FFFE, "cnt_pre");
    xfer(0, 1, 11'h004, 4'hF, 32'h3, rdata, cyc);
    m_ctrl = 2'b11;
    base = 32'hFFFF_FFFE + RL;
    for (int k = 0; k < 3; k++) begin
      xfer(1, 0, 11'h00C, 4'hF, 0, rdata, cyc);
      chk("cnt_wrap", rdata, base + 32'(k * (RL + 2)));
    end
    xfer(0, 1, 11'h00C, 4'hF, 32'd5, rdata, cyc);
    xfer(1, 0, 11'h00C, 4'hF, 0, rdata, cyc);
    chk("cnt_wr_prio", rdata, 32'd5 + RL);
    m_last_rd = rdata;
    do_op(0, 1, 11'h004, 4'hF, 32'h0, "ctrl_halt");
    m_cnt = 32'd5 + 32'(2 * (RL + 2));
    do_op(1, 0, 11'h00C, 4'hF, 0, "cnt_halted");
    do_op(1, 0, 11'h008, 4'hF, 0, "st_nomatch");

    // reset in the middle of a scratch write
    do_op(0, 1, 11'h108, 4'hF, 32'hAAAA_5555, "rst_pre2");
    do_op(0, 1, 11'h10C, 4'hF, 32'h0BAD_F00D, "rst_pre3");
    do_op(0, 1, 11'h004, 4'hF, 32'h2, "rst_pre_ctrl");
    bus.avs_address = 11'h108; bus.avs_byteenable = 4'hF;
    bus.avs_writedata = 32'h600D_CAFE; bus.avs_write = 1'b1;
    @(posedge ACLK); #1 ARESETN = 1'b0;
    @(posedge ACLK); #1 ARESETN = 1'b1;
    cyc = 0;
    do begin @(negedge ACLK); cyc++; end while (bus.avs_waitrequest && cyc < 40);
    chk("rst_restart_lat", cyc, RL + 2);
    chk("rst_rd_zero", bus.avs_readdata, 32'd0);
    @(posedge ACLK); #1 bus.avs_write = 1'b0;
    m_reset();
    m_scr[2] = 32'h600D_CAFE;
    do_op(1, 0, 11'h108, 4'hF, 0, "rst_scr2");
    do_op(1, 0, 11'h10C, 4'hF, 0, "rst_scr3");
    do_op(1, 0, 11'h004, 4'hF, 0, "rst_ctrl");
    do_op(1, 0, 11'h008, 4'hF, 0, "rst_stat");
    do_op(1, 0, 11'h00C, 4'hF, 0, "rst_cnt");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
